// File: rtl/int_claim_arbiter.sv
// int_claim_arbiter: interrupt gateway plus priority arbiter for a single hart.
//
// Ports:
//   clock, reset       sole clock; asynchronous active-low reset
//   int_in[N_SRC]      async interrupt lines, bit i = source ID i+1
//   edge_mode[N_SRC]   1 = rising-edge gateway, 0 = level gateway
//   enable[N_SRC]      per-source arbitration enable (does not clear pending)
//   prio               per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   threshold          a source is eligible only when prio > threshold
//   irq_out            registered, high when claim_id != 0
//   claim_valid        claim strobe; claims the source named by claim_id
//   claim_id           registered winning source ID (0 = none)
//   complete_valid/id  completion strobe and the ID being completed
//
// Each line passes a 2-flop synchronizer (s1, s2), with s3 kept for rising-edge
// detection. A per-source gateway tracks IDLE/PENDING/INFLIGHT plus a 2-bit
// saturating count of edges seen while already pending or in flight.

module int_claim_gateway (
  input  logic clock,
  input  logic reset,
  input  logic s2,         // synchronized level
  input  logic rise,       // synchronized rising edge
  input  logic edge_mode,
  input  logic claim_hit,  // claim addressed to this source
  input  logic comp_hit,   // complete addressed to this source
  output logic arb_pend    // pending after this cycle's claim/complete
);

  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_INFLIGHT} gw_state_t;

  gw_state_t  st, st_n;
  logic [1:0] ecnt, ecnt_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st   <= GW_IDLE;
      ecnt <= 2'd0;
    end else begin
      st   <= st_n;
      ecnt <= ecnt_n;
    end
  end

  always_comb begin
    st_n   = st;
    ecnt_n = ecnt;
    case (st)
      GW_IDLE: begin
        if (edge_mode ? rise : s2) st_n = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim_hit) st_n = GW_INFLIGHT;
        if (edge_mode && rise && ecnt != 2'd3) ecnt_n = ecnt + 2'd1;
      end
      GW_INFLIGHT: begin
        if (comp_hit) begin
          if (edge_mode && ecnt != 2'd0) begin
            // Replay one banked edge; a coincident rise cancels the decrement.
            st_n = GW_PENDING;
            if (!rise) ecnt_n = ecnt - 2'd1;
          end else if (edge_mode && rise) begin
            st_n = GW_PENDING;
          end else begin
            // Level mode: a still-high line re-pends from IDLE on the next edge.
            st_n = GW_IDLE;
          end
        end else if (edge_mode && rise && ecnt != 2'd3) begin
          ecnt_n = ecnt + 2'd1;
        end
      end
      default: st_n = GW_IDLE;
    endcase
    if (!edge_mode) ecnt_n = 2'd0;
  end

  // Claim/complete effects are folded in so back-to-back claims never see a
  // stale winner; fresh arrivals from IDLE reach the arbiter one cycle later,
  // which gives the four-edge int_in -> irq_out latency.
  assign arb_pend = (st_n == GW_PENDING) && (st != GW_IDLE);

endmodule

module int_claim_arbiter #(
  parameter int N_SRC  = 5,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        int_in,
  input  logic [N_SRC-1:0]        edge_mode,
  input  logic [N_SRC-1:0]        enable,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]       threshold,
  output logic                    irq_out,
  input  logic                    claim_valid,
  output logic [ID_W-1:0]         claim_id,
  input  logic                    complete_valid,
  input  logic [ID_W-1:0]         complete_id
);

  logic [N_SRC-1:0] s1, s2, s3;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] arb_pend;
  logic [ID_W-1:0]  best_n;
  logic [PRIO_W-1:0] best_p;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= int_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_gw
      int_claim_gateway u_gw (
        .clock     (clock),
        .reset     (reset),
        .s2        (s2[g]),
        .rise      (rise[g]),
        .edge_mode (edge_mode[g]),
        .claim_hit (claim_valid && (claim_id == ID_W'(g + 1))),
        .comp_hit  (complete_valid && (complete_id == ID_W'(g + 1))),
        .arb_pend  (arb_pend[g])
      );
    end
  endgenerate

  // Seeding the running max with threshold enforces prio > threshold; strict
  // compare in ascending order hands ties to the lowest ID.
  always_comb begin
    best_n = '0;
    best_p = threshold;
    for (int i = 0; i < N_SRC; i++) begin
      if (arb_pend[i] && enable[i] && (prio[i*PRIO_W +: PRIO_W] > best_p)) begin
        best_p = prio[i*PRIO_W +: PRIO_W];
        best_n = ID_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      claim_id <= '0;
      irq_out  <= 1'b0;
    end else begin
      claim_id <= best_n;
      irq_out  <= (best_n != '0);
    end
  end

endmodule

// File: tb/tb_int_claim_arbiter.sv
// Directed bench for int_claim_arbiter. Stimulus pushes expected
// {irq_out, claim_id} with a target cycle into a scoreboard queue; an
// independent monitor compares them shortly after each falling edge.

module tb_int_claim_arbiter;

  localparam int N = 5;
  localparam int PW = 3;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  int_in, edge_mode, enable;
  logic [N*PW-1:0] prio;
  logic [PW-1:0] threshold;
  logic          irq_out, claim_valid, complete_valid;
  logic [IW-1:0] claim_id, complete_id;

  always #5 clock = ~clock;

  int_claim_arbiter #(.N_SRC(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset), .int_in(int_in), .edge_mode(edge_mode),
    .enable(enable), .prio(prio), .threshold(threshold), .irq_out(irq_out),
    .claim_valid(claim_valid), .claim_id(claim_id),
    .complete_valid(complete_valid), .complete_id(complete_id)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int          q_cyc[$];
  logic [3:0]  q_exp[$];
  string       q_nm[$];

  task automatic expect_at(input int dly, input logic irq, input logic [2:0] id,
                           input string nm);
    q_cyc.push_back(cyc + dly);
    q_exp.push_back({irq, id});
    q_nm.push_back(nm);
  endtask

  // Monitor: outputs are stable away from the rising edge.
  always begin
    @(negedge clock);
    #1;
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      n_tests++;
      if (q_cyc[0] < cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", q_nm[0], q_cyc[0], cyc);
      end else if ({irq_out, claim_id} !== q_exp[0]) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got irq=%0b id=%0d, want irq=%0b id=%0d",
                 q_nm[0], cyc, irq_out, claim_id, q_exp[0][3], q_exp[0][2:0]);
      end
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_nm.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_prio(input int src, input logic [PW-1:0] v);
    prio[(src-1)*PW +: PW] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    int_in = '0; edge_mode = '0; enable = '0; prio = '0; threshold = '0;
    claim_valid = 1'b0; complete_valid = 1'b0; complete_id = '0;
    expect_at(0, 1'b0, 3'd0, "reset_state");
    step(2);
    reset = 1'b1;
  endtask

  // One-cycle claim; expected outcome is visible one edge later.
  task automatic claim(input logic irq, input logic [2:0] id, input string nm);
    claim_valid = 1'b1;
    expect_at(1, irq, id, nm);
    step(1);
    claim_valid = 1'b0;
  endtask

  task automatic complete(input logic [2:0] id);
    complete_valid = 1'b1;
    complete_id = id;
    step(1);
    complete_valid = 1'b0;
    complete_id = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    int_in = '0; edge_mode = '0; enable = '0; prio = '0; threshold = '0;
    claim_valid = 1'b0; complete_valid = 1'b0; complete_id = '0;

    // ---- Level, basic ----
    do_reset();
    int_in = 5'b00100; enable = '1; set_prio(3, 3'd5);
    expect_at(3, 1'b0, 3'd0, "lvl_latency_e3");
    expect_at(4, 1'b1, 3'd3, "lvl_latency_e4");
    step(4);
    claim(1'b0, 3'd0, "lvl_claim");
    expect_at(2, 1'b0, 3'd0, "lvl_inflight_ignores_level");
    step(2);
    expect_at(2, 1'b0, 3'd0, "lvl_complete_idle");
    expect_at(3, 1'b1, 3'd3, "lvl_repend");
    complete(3'd3);
    step(2);

    // ---- Priority and tie ----
    do_reset();
    int_in = 5'b01011; enable = '1;
    set_prio(1, 3'd2); set_prio(2, 3'd6); set_prio(4, 3'd6);
    expect_at(4, 1'b1, 3'd2, "prio_tie_low_id");
    step(4);
    claim(1'b1, 3'd4, "prio_next_after_claim");
    claim(1'b1, 3'd1, "prio_lowest");
    claim(1'b0, 3'd0, "prio_all_inflight");

    // ---- Threshold and enable ----
    do_reset();
    int_in = 5'b10000; enable = '1; set_prio(5, 3'd3); threshold = 3'd3;
    expect_at(5, 1'b0, 3'd0, "thr_equal_blocks");
    step(5);
    threshold = 3'd2;
    expect_at(1, 1'b1, 3'd5, "thr_lowered");
    step(1);
    enable[4] = 1'b0;
    expect_at(1, 1'b0, 3'd0, "en_disabled");
    step(3);
    enable[4] = 1'b1;
    expect_at(1, 1'b1, 3'd5, "en_pending_retained");
    step(1);

    // ---- Edge counting ----
    do_reset();
    edge_mode = 5'b00001; enable = '1; set_prio(1, 3'd4);
    int_in[0] = 1'b1;
    expect_at(4, 1'b1, 3'd1, "edge_latency_e4");
    step(4);
    claim(1'b0, 3'd0, "edge_claim");
    for (int r = 0; r < 4; r++) begin
      int_in[0] = 1'b0; step(3);
      int_in[0] = 1'b1; step(3);
    end
    int_in[0] = 1'b0;
    expect_at(1, 1'b0, 3'd0, "edge_inflight_counting");
    step(3);
    for (int r = 0; r < 3; r++) begin
      expect_at(1, 1'b1, 3'd1, "edge_replay");
      complete(3'd1);
      claim(1'b0, 3'd0, "edge_reclaim");
    end
    expect_at(1, 1'b0, 3'd0, "edge_saturated_done");
    complete(3'd1);
    expect_at(4, 1'b0, 3'd0, "edge_stays_idle");
    step(4);

    // ---- Bad completes and empty claim ----
    do_reset();
    int_in = 5'b00100; enable = '1; set_prio(3, 3'd5);
    expect_at(4, 1'b1, 3'd3, "bad_setup");
    step(4);
    claim(1'b0, 3'd0, "bad_claim3");
    expect_at(1, 1'b0, 3'd0, "bad_cmp_id0");
    complete(3'd0);
    expect_at(1, 1'b0, 3'd0, "bad_cmp_id6");
    complete(3'd6);
    expect_at(1, 1'b0, 3'd0, "bad_cmp_idle2");
    complete(3'd2);
    expect_at(3, 1'b1, 3'd3, "bad_src3_still_inflight");
    complete(3'd3);
    step(2);
    claim(1'b0, 3'd0, "bad_claim3_again");
    claim(1'b0, 3'd0, "claim_id0_noop");
    expect_at(3, 1'b1, 3'd3, "claim_id0_state_kept");
    complete(3'd3);
    step(2);

    // ---- Reset mid-operation ----
    do_reset();
    int_in = 5'b00101; enable = '1; set_prio(3, 3'd5); set_prio(1, 3'd2);
    expect_at(4, 1'b1, 3'd3, "rst_setup");
    step(4);
    claim(1'b1, 3'd1, "rst_src1_pending");
    #3;
    reset = 1'b0;
    int_in = '0;
    expect_at(1, 1'b0, 3'd0, "rst_async_clear");
    step(1);
    reset = 1'b1;
    expect_at(1, 1'b0, 3'd0, "rst_late_complete");
    complete(3'd3);
    int_in[0] = 1'b1;
    expect_at(3, 1'b0, 3'd0, "rst_fresh_e3");
    expect_at(4, 1'b1, 3'd1, "rst_fresh_e4");
    step(4);

    step(6);
    while (q_cyc.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (target cycle %0d)", q_nm[0], q_cyc[0]);
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_nm.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_claim_arbiter.md
Name: int_claim_arbiter

Overview:
Interrupt gateway and priority arbiter that sits after the interrupt crossbar. It consumes the crossbar's flattened, asynchronous interrupt lines and synchronizes each one. Each source gets a per-source gateway (level or edge mode) that tracks pending and in-flight state. Enabled pending sources are arbitrated by priority against a threshold, and the result is presented to one hart through a claim/complete handshake.

Parameters:
N_SRC, 5, number of interrupt sources (crossbar output width)
PRIO_W, 3, priority field width; priority 0 means never taken
ID_W, 3, source-ID width, equal to clog2(N_SRC+1); ID 0 means "none", sources are 1..N_SRC

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset (asserted low, released synchronously to clock by the reset tree)
int_in  in  N_SRC  raw interrupt lines from the crossbar; bit i is source ID i+1
edge_mode  in  N_SRC  per-source gateway mode: 1 = rising-edge, 0 = level
enable  in  N_SRC  per-source arbitration enable
prio  in  N_SRC*PRIO_W  per-source priority; source i occupies bits [i*PRIO_W +: PRIO_W]
threshold  in  PRIO_W  a source is eligible only if prio > threshold
irq_out  out  1  registered; high when best_id != 0
claim_valid  in  1  single-cycle claim strobe
claim_id  out  ID_W  registered best_id; the value sampled by the hart on a claim
complete_valid  in  1  single-cycle completion strobe
complete_id  in  ID_W  ID being completed

Behaviour:
- Synchronizer: 2 flops per line (s1, s2) plus s3 for edge detection. All reset to 0.
- Gateway states per source: IDLE, PENDING, INFLIGHT. Each source also has a 2-bit saturating edge counter ecnt.
- Level mode:
  - IDLE and s2=1 -> PENDING.
  - INFLIGHT ignores the level.
  - ecnt is unused and held at 0.
- Edge mode:
  - A rise is s2 & ~s3.
  - IDLE and rise -> PENDING.
  - PENDING or INFLIGHT and rise -> ecnt = min(ecnt+1, 3).
- Claim:
  - claim_valid with claim_id = k != 0 moves gateway k from PENDING to INFLIGHT at that edge.
  - claim_valid with claim_id = 0 has no effect.
- Complete:
  - complete_valid with complete_id = k, 1 <= k <= N_SRC, and gateway k INFLIGHT resolves as follows:
    - Edge mode with ecnt > 0: -> PENDING, ecnt decremented.
    - Otherwise: -> IDLE. In level mode, a still-high line re-pends on the next edge.
  - A complete_id of 0, out of range, or naming a non-INFLIGHT gateway is ignored. No error is raised.
- Eligibility and arbitration:
  - Eligible = PENDING & enable & (prio > threshold).
  - Disabling a source does not clear its pending state.
  - The winner is the highest prio; ties go to the lowest ID.
- Arbitration latency:
  - best_id is computed from next-state pending (after this cycle's claim and complete) and registered.
  - A claim in the cycle immediately after a claim therefore sees an up-to-date ID, never a stale one.
  - irq_out equals (best_id != 0) and is registered together with best_id.
- End-to-end latency: int_in stable high before edge E1 gives s1@E1, s2@E2, PENDING@E3, irq_out/claim_id valid after E4. This holds for both modes.
- Simultaneous events:
  - A claim of source a and a complete of source b≠a in the same cycle are both applied.
  - A complete naming the ID being claimed in that same cycle is ignored, because the gateway is not yet INFLIGHT.
  - A rise coinciding with a complete that has ecnt = 0 sets PENDING directly.
  - A rise coinciding with a complete that has ecnt > 0 leaves ecnt unchanged, i.e. +1 and -1 cancel.
- Configuration changes: changes to prio, enable and threshold take effect on the next registered best_id.
- Reset values: all gateways IDLE, ecnt = 0, sync flops 0, best_id = 0, irq_out = 0, claim_id = 0.
- Reset mid-operation: any INFLIGHT claim is dropped, and a later complete for it is ignored.

Test Plan:
- Level, basic: int_in[2]=1, edge_mode=0, enable=all, prio3=5, threshold=0 -> irq_out=1 and claim_id=3 four edges later. Claim -> irq_out=0 next cycle. Complete(3) with the line still high -> re-pend, irq_out=1 two edges later.
- Priority and tie: sources 1, 2, 4 pending with prio 2, 6, 6 -> claim_id=2. Claim -> claim_id=4 next cycle. Claim -> claim_id=1.
- Threshold and enable: prio5=3, threshold=3 -> irq_out stays 0. Then threshold=2 -> irq_out=1 with claim_id=5. Then enable[4]=0 -> irq_out=0, pending retained. Re-enable -> claim_id=5.
- Edge counting: edge_mode[0]=1, source 1 claimed. Then 4 rising edges arrive -> ecnt saturates at 3. Over 4 complete(1)/claim cycles the source re-pends exactly 3 times, then stays IDLE.
- Bad completes: complete_id 0, 6, and 2 (with 2 IDLE) -> no state change. A claim with best_id=0 returns 0 and changes nothing.
- Reset mid-operation: source 3 INFLIGHT and source 1 PENDING, pulse reset low asynchronously -> irq_out, claim_id and all state 0 immediately. A later complete(3) is ignored.
